cpu_control_unit: RTL and testbench

- Multi-cycle fetch/decode/execute sequencer for the 8-bit accumulator CPU.
- Owns the program counter and instruction register, and drives the instruction ROM address.
- Decodes {opcode[7:5], operand[4:0]} into strobes for the accumulator, ALU, data memory and output port.
- Sits between instruction_rom and the datapath (accumulator, ALU, 32-entry data RAM with synchronous read).

---
 rtl/cpu_control_unit.sv | 128 ++++++++++++
 tb/tb_cpu_control_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_control_unit.sv
// cpu_control_unit: multi-cycle fetch/decode/execute sequencer for the 8-bit
// accumulator CPU. Owns PC and IR, drives the instruction ROM address and
// decodes {opcode, operand} into datapath strobes.
module cpu_control_unit #(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_run,
  input  logic [7:0]        i_instruction,
  output logic [ADDR_W-1:0] o_rom_addr,
  output logic [ADDR_W-1:0] o_pc,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_we,
  output logic              o_acc_we,
  output logic [1:0]        o_alu_op,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic              o_halted,
  output logic [2:0]        o_state
);

  typedef enum logic [2:0] {
    S_FETCH    = 3'd0,
    S_DECODE   = 3'd1,
    S_EXECUTE  = 3'd2,
    S_OUT_WAIT = 3'd3,
    S_HALTED   = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_LOAD  = 3'd1,
    OP_STORE = 3'd2,
    OP_ADD   = 3'd3,
    OP_SUB   = 3'd4,
    OP_JMP   = 3'd5,
    OP_HALT  = 3'd6,
    OP_OUT   = 3'd7
  } opcode_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [7:0]        r_ir;

  opcode_t           w_opcode;
  logic [ADDR_W-1:0] w_operand;

  assign w_opcode  = opcode_t'(r_ir[7:5]);
  assign w_operand = ADDR_W'(r_ir[4:0]);

  // Sequencer: PC, IR and state advance; JMP in EXECUTE overrides the FETCH increment.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_FETCH;
      r_pc    <= ADDR_W'(RESET_PC);
      r_ir    <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (i_run) begin
            r_ir    <= i_instruction;
            r_pc    <= r_pc + ADDR_W'(1);
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_state <= S_EXECUTE;
        end
        S_EXECUTE: begin
          case (w_opcode)
            OP_JMP: begin
              r_pc    <= w_operand;
              r_state <= S_FETCH;
            end
            OP_HALT: r_state <= S_HALTED;
            OP_OUT:  r_state <= i_out_ready ? S_FETCH : S_OUT_WAIT;
            default: r_state <= S_FETCH;
          endcase
        end
        S_OUT_WAIT: begin
          if (i_out_ready) r_state <= S_FETCH;
        end
        S_HALTED: begin
          r_state <= S_HALTED;
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

  // Strobe decode from state and IR; combinational so async reset drops out_valid at once.
  always_comb begin
    o_mem_we    = 1'b0;
    o_acc_we    = 1'b0;
    o_alu_op    = 2'b00;
    o_out_valid = 1'b0;
    if (r_state == S_EXECUTE) begin
      case (w_opcode)
        OP_LOAD: begin
          o_acc_we = 1'b1;
          o_alu_op = 2'b00;
        end
        OP_ADD: begin
          o_acc_we = 1'b1;
          o_alu_op = 2'b01;
        end
        OP_SUB: begin
          o_acc_we = 1'b1;
          o_alu_op = 2'b10;
        end
        OP_STORE: o_mem_we    = 1'b1;
        OP_OUT:   o_out_valid = 1'b1;
        default: ;
      endcase
    end else if (r_state == S_OUT_WAIT) begin
      o_out_valid = 1'b1;
    end
  end

  assign o_rom_addr = r_pc;
  assign o_pc       = r_pc;
  assign o_mem_addr = w_operand;
  assign o_halted   = (r_state == S_HALTED);
  assign o_state    = r_state;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Self-checking bench for cpu_control_unit: an instruction-level reference
// model predicts per-cycle outputs for directed and randomized programs.
module tb_cpu_control_unit;

  localparam int NOP = 0, LOAD = 1, STORE = 2, ADD = 3, SUB = 4, JMP = 5, HALT = 6, OUT = 7;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic       out_ready;
  logic [7:0] instruction;
  logic [4:0] rom_addr, pc, mem_addr;
  logic       mem_we, acc_we, out_valid, halted;
  logic [1:0] alu_op;
  logic [2:0] state;

  logic [7:0] rom [32];
  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int m_pc;

  cpu_control_unit #(.ADDR_W(5), .RESET_PC(0)) dut (
    .i_clk(clk), .i_rst(rst), .i_run(run), .i_instruction(instruction),
    .o_rom_addr(rom_addr), .o_pc(pc), .o_mem_addr(mem_addr),
    .o_mem_we(mem_we), .o_acc_we(acc_we), .o_alu_op(alu_op),
    .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_halted(halted), .o_state(state)
  );

  // Combinational instruction ROM
  assign instruction = rom[rom_addr];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] ins(input int op, input int a);
    return 8'((op << 5) | (a & 31));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk_cycle(input string ph, input int st, input int pcv,
                           input int accw, input int memw, input int outv, input int hlt);
    chk({ph, "_state"},     32'(state),     32'(st));
    chk({ph, "_pc"},        32'(pc),        32'(pcv));
    chk({ph, "_rom_addr"},  32'(rom_addr),  32'(pcv));
    chk({ph, "_acc_we"},    32'(acc_we),    32'(accw));
    chk({ph, "_mem_we"},    32'(mem_we),    32'(memw));
    chk({ph, "_out_valid"}, 32'(out_valid), 32'(outv));
    chk({ph, "_halted"},    32'(halted),    32'(hlt));
  endtask

  // Assert reset at a negedge, check outputs before the next edge, release at the next negedge
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk_cycle("reset", 0, 0, 0, 0, 0, 0);
    chk("reset_alu_op", 32'(alu_op), 32'd0);
    chk("reset_mem_addr", 32'(mem_addr), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    m_pc = 0;
  endtask

  // Execute one instruction at m_pc from the reference model's point of view.
  // Called at a negedge in FETCH; returns at the negedge of the following FETCH.
  task automatic do_instr(input int idle, input int delay);
    logic [7:0] w;
    int op, a, pc0, nxt, is_acc, exp_alu;
    pc0 = m_pc;
    w   = rom[pc0];
    op  = int'(w[7:5]);
    a   = int'(w[4:0]);
    nxt = (pc0 + 1) % 32;
    is_acc  = (op == LOAD || op == ADD || op == SUB) ? 1 : 0;
    exp_alu = (op == ADD) ? 1 : (op == SUB) ? 2 : 0;
    for (int i = 0; i < idle; i++) begin
      run = 1'b0;
      chk_cycle("idle", 0, pc0, 0, 0, 0, 0);
      @(negedge clk);
    end
    run = 1'b1;
    chk_cycle("fetch", 0, pc0, 0, 0, 0, 0);
    @(negedge clk);
    run = 1'($urandom_range(0, 1));
    chk_cycle("decode", 1, nxt, 0, 0, 0, 0);
    chk("decode_mem_addr", 32'(mem_addr), 32'(a));
    @(negedge clk);
    run = 1'($urandom_range(0, 1));
    chk_cycle("exec", 2, nxt, is_acc, (op == STORE) ? 1 : 0, (op == OUT) ? 1 : 0, 0);
    chk("exec_mem_addr", 32'(mem_addr), 32'(a));
    if (is_acc != 0) chk("exec_alu_op", 32'(alu_op), 32'(exp_alu));
    if (op == OUT) begin
      out_ready = (delay == 0);
      @(negedge clk);
      for (int k = 1; k <= delay; k++) begin
        chk_cycle("outwait", 3, nxt, 0, 0, 1, 0);
        out_ready = (k == delay);
        @(negedge clk);
      end
      out_ready = 1'b0;
    end else begin
      @(negedge clk);
    end
    m_pc = (op == JMP) ? a : nxt;
  endtask

  initial begin
    int start, op;
    rst = 1'b1;
    run = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 32; i++) rom[i] = ins(NOP, 0);

    // Demo program loop: LOAD 1, ADD 2, SUB 3, STORE 4, OUT, JMP 0
    rom[0] = ins(LOAD, 1);
    rom[1] = ins(ADD, 2);
    rom[2] = ins(SUB, 3);
    rom[3] = ins(STORE, 4);
    rom[4] = ins(OUT, 0);
    rom[5] = ins(JMP, 0);
    do_reset();
    start = cyc;
    for (int i = 0; i < 6; i++) do_instr(0, 0);
    chk("loop_cycles", 32'(cyc - start), 32'd18);
    chk("loop_pc", 32'(pc), 32'd0);
    start = cyc;
    for (int i = 0; i < 6; i++) do_instr(0, 0);
    chk("loop2_cycles", 32'(cyc - start), 32'd18);

    // OUT with back-pressure for 4 cycles, then run=0 for 10 cycles in FETCH
    for (int i = 0; i < 4; i++) do_instr(0, 0);
    start = cyc;
    do_instr(0, 4);
    chk("out_wait_cycles", 32'(cyc - start), 32'd7);
    do_instr(10, 0);
    chk("after_idle_pc", 32'(pc), 32'd0);

    // Randomized programs (no HALT) with random idles and OUT back-pressure
    for (int i = 0; i < 32; i++) begin
      op = int'($urandom_range(0, 6));
      if (op == HALT) op = OUT;
      rom[i] = ins(op, int'($urandom_range(0, 31)));
    end
    do_reset();
    for (int i = 0; i < 150; i++) do_instr(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));

    // PC wrap with straight-line NOPs
    for (int i = 0; i < 32; i++) rom[i] = ins(NOP, i);
    do_reset();
    for (int i = 0; i < 34; i++) do_instr(0, 0);
    chk("wrap_pc", 32'(pc), 32'd2);

    // HALT at address 7: frozen until reset regardless of run
    rom[7] = ins(HALT, 0);
    do_reset();
    for (int i = 0; i < 8; i++) do_instr(0, 0);
    for (int i = 0; i < 20; i++) begin
      run = 1'($urandom_range(0, 1));
      chk_cycle("halted", 4, 8, 0, 0, 0, 1);
      @(negedge clk);
    end
    do_reset();
    rom[7] = ins(NOP, 0);

    // Async reset in the middle of an OUT_WAIT handshake
    rom[0] = ins(OUT, 0);
    rom[1] = ins(JMP, 0);
    run = 1'b1;
    @(negedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    @(negedge clk);
    chk_cycle("pre_abort", 3, 1, 0, 0, 1, 0);
    #2;
    rst = 1'b1;
    #1;
    chk_cycle("abort", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    m_pc = 0;
    do_instr(0, 2);
    do_instr(0, 0);
    chk("post_abort_pc", 32'(pc), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
